enc_pkt_sched: RTL

Packet scheduler that sits in front of the 8b/10b encoder (`enc8to10`) and shares it between two byte-stream requesters. It arbitrates round-robin at packet boundaries and frames each packet as the encoder expects: four K28.1 start words with `startin` on the first, then payload, then a K28.5 terminator. After the terminator it holds the encoder input quiet while the encoder emits its CRC words and closing K28.5. Payload bytes that would falsely terminate the frame are screened out, and over-length packets are cut.

---
 rtl/enc_pkt_sched.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/enc_pkt_sched.sv
// Two-requester packet scheduler feeding an 8b/10b encoder: round-robin at packet
// boundaries, K28.1 x4 start framing, K28.5 terminator, comma screening and length cut.
module enc_pkt_sched #(
  parameter int unsigned GAP     = 5,
  parameter int unsigned MAX_LEN = 256
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0_valid,
  input  logic [7:0] req0_data,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_data,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic       enc_pushin,
  output logic [8:0] enc_datain,
  output logic       enc_startin,
  output logic       grant,
  output logic       busy,
  output logic       err_abort
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [8:0] K28_1 = 9'h13C;
  localparam logic [8:0] K28_5 = 9'h1BC;
  localparam logic [7:0] COMMA = 8'hBC;

  typedef enum logic [2:0] {ST_IDLE, ST_SOP, ST_DATA, ST_EOP, ST_DRAIN, ST_GAP} state_t;

  state_t        state, state_n;
  logic [1:0]    sop_cnt, sop_cnt_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic [CW-1:0] pay_cnt, pay_cnt_n;
  logic          abort_pend, abort_pend_n;
  logic          drain_pend, drain_pend_n;
  logic          last_gnt, last_gnt_n;
  logic          grant_n, busy_n, err_abort_n, push_n, start_n;
  logic [8:0]    data_n;
  logic          sel_valid, sel_last;
  logic [7:0]    sel_data;

  always_comb begin
    sel_valid  = grant ? req1_valid : req0_valid;
    sel_data   = grant ? req1_data  : req0_data;
    sel_last   = grant ? req1_last  : req0_last;
    req0_ready = ((state == ST_DATA) || (state == ST_DRAIN)) && !grant;
    req1_ready = ((state == ST_DATA) || (state == ST_DRAIN)) && grant;
  end

  // Outputs are registered from the current state's action, so each word shows up one cycle after its state cycle.
  always_comb begin
    state_n      = state;
    sop_cnt_n    = sop_cnt;
    gap_cnt_n    = gap_cnt;
    pay_cnt_n    = pay_cnt;
    abort_pend_n = abort_pend;
    drain_pend_n = drain_pend;
    last_gnt_n   = last_gnt;
    grant_n      = grant;
    busy_n       = (state != ST_IDLE);
    err_abort_n  = 1'b0;
    push_n       = 1'b0;
    start_n      = 1'b0;
    data_n       = '0;
    case (state)
      ST_IDLE: begin
        if (req0_valid || req1_valid) begin
          grant_n    = (req0_valid && req1_valid) ? ~last_gnt : req1_valid;
          last_gnt_n = grant_n;
          sop_cnt_n  = '0;
          state_n    = ST_SOP;
        end
      end
      ST_SOP: begin
        push_n       = 1'b1;
        data_n       = K28_1;
        start_n      = (sop_cnt == 2'd0);
        sop_cnt_n    = sop_cnt + 2'd1;
        pay_cnt_n    = '0;
        abort_pend_n = 1'b0;
        drain_pend_n = 1'b0;
        if (sop_cnt == 2'd3) state_n = ST_DATA;
      end
      ST_DATA: begin
        if (sel_valid) begin
          // A raw 0xBC would be taken as K28.5 by the encoder, so it ends the frame instead.
          if (sel_data == COMMA) begin
            abort_pend_n = 1'b1;
            drain_pend_n = !sel_last;
            state_n      = ST_EOP;
          end else begin
            push_n    = 1'b1;
            data_n    = {1'b0, sel_data};
            pay_cnt_n = pay_cnt + CW'(1);
            if (sel_last) begin
              state_n = ST_EOP;
            end else if (pay_cnt + CW'(1) == CW'(MAX_LEN)) begin
              abort_pend_n = 1'b1;
              drain_pend_n = 1'b1;
              state_n      = ST_EOP;
            end
          end
        end
      end
      ST_EOP: begin
        push_n      = 1'b1;
        data_n      = K28_5;
        err_abort_n = abort_pend;
        gap_cnt_n   = '0;
        state_n     = drain_pend ? ST_DRAIN : ST_GAP;
      end
      ST_DRAIN: begin
        if (sel_valid && sel_last) state_n = ST_GAP;
      end
      ST_GAP: begin
        gap_cnt_n = gap_cnt + GW'(1);
        if (gap_cnt == GW'(GAP - 1)) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= ST_IDLE;
      sop_cnt     <= '0;
      gap_cnt     <= '0;
      pay_cnt     <= '0;
      abort_pend  <= 1'b0;
      drain_pend  <= 1'b0;
      last_gnt    <= 1'b1;
      grant       <= 1'b0;
      busy        <= 1'b0;
      err_abort   <= 1'b0;
      enc_pushin  <= 1'b0;
      enc_datain  <= '0;
      enc_startin <= 1'b0;
    end else begin
      state       <= state_n;
      sop_cnt     <= sop_cnt_n;
      gap_cnt     <= gap_cnt_n;
      pay_cnt     <= pay_cnt_n;
      abort_pend  <= abort_pend_n;
      drain_pend  <= drain_pend_n;
      last_gnt    <= last_gnt_n;
      grant       <= grant_n;
      busy        <= busy_n;
      err_abort   <= err_abort_n;
      enc_pushin  <= push_n;
      enc_datain  <= data_n;
      enc_startin <= start_n;
    end
  end

endmodule
